// File: rtl/lockstep_mem_ctrl_pkg.sv
// Shared definitions for the lockstep memory controller.
//  - state_e     : controller FSM states
//  - Err*        : err_code values reported on lockstep_err
//  - mem_req_t   : one picorv32 native-port request (instr, addr, wdata, wstrb)
//  - lane_mask() : expands byte strobes into a 32-bit data mask
package lockstep_defs;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StIssue,
        StResp,
        StErr
    } state_e;

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrMismatch = 2'b01;
    localparam logic [1:0] ErrTimeout  = 2'b10;
    localparam logic [1:0] ErrProtocol = 2'b11;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

endpackage

// File: rtl/lockstep_mem_ctrl_if.sv
// picorv32 native memory port bundle.
//  valid/instr/addr/wdata/wstrb : request, driven by the requester (master)
//  ready/rdata                  : response, driven by the responder (slave)
interface lockstep_mem_ctrl_if;

    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );

endinterface

// File: rtl/lockstep_mem_ctrl_req_cmp.sv
// Combinational comparator for the two lockstep core requests.
//  *_0_i / *_1_i : request fields from core0 / core1
//  match_o       : 1 when addr, wstrb and instr are equal and write data agrees
//                  in every byte lane enabled by wstrb (reads ignore wdata)
module lockstep_req_cmp
    import lockstep_defs::*;
(
    input  logic        instr_0_i,
    input  logic [31:0] addr_0_i,
    input  logic [31:0] wdata_0_i,
    input  logic [3:0]  wstrb_0_i,
    input  logic        instr_1_i,
    input  logic [31:0] addr_1_i,
    input  logic [31:0] wdata_1_i,
    input  logic [3:0]  wstrb_1_i,
    output logic        match_o
);

    // Strobes must already be equal for a match, so core0's mask covers both.
    logic [31:0] data_diff;

    assign data_diff = (wdata_0_i ^ wdata_1_i) & lane_mask(wstrb_0_i);

    assign match_o = (addr_0_i == addr_1_i) && (wstrb_0_i == wstrb_1_i) &&
                     (instr_0_i == instr_1_i) && (data_diff == '0);

endmodule

// File: rtl/lockstep_mem_ctrl.sv
// Lockstep memory controller: two redundant picorv32 cores share one memory port.
//  clk, resetn      : clock, asynchronous active-low reset
//  core0_if/core1_if: core request ports (slave side)
//  mem_if           : downstream memory port (master side)
//  err_clr          : one-cycle pulse leaving the error state
//  lockstep_err     : sticky error flag
//  err_code         : first error cause (01 mismatch, 10 timeout, 11 protocol)
// Both cores must request; matching requests produce one downstream transfer whose
// response is returned to both cores in the same cycle.
module lockstep_mem_ctrl
    import lockstep_defs::*;
#(
    parameter int unsigned SKEW_MAX = 15
) (
    input  logic                       clk,
    input  logic                       resetn,
    lockstep_mem_ctrl_if.slave         core0_if,
    lockstep_mem_ctrl_if.slave         core1_if,
    lockstep_mem_ctrl_if.master        mem_if,
    input  logic                       err_clr,
    output logic                       lockstep_err,
    output logic [1:0]                 err_code
);

    localparam int unsigned     CntW   = $clog2(SKEW_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(SKEW_MAX);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wait1_q, wait1_d;     // 1: core1 is the core waiting in StWait
    logic            mem_valid_q, mem_valid_d;
    mem_req_t        req_q, req_d;
    logic            ready_q, ready_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;

    logic            v0, v1, both_valid, waiter_valid, req_match, do_cmp;

    assign v0           = core0_if.valid;
    assign v1           = core1_if.valid;
    assign both_valid   = v0 && v1;
    assign waiter_valid = wait1_q ? v1 : v0;

    lockstep_req_cmp u_req_cmp (
        .instr_0_i (core0_if.instr),
        .addr_0_i  (core0_if.addr),
        .wdata_0_i (core0_if.wdata),
        .wstrb_0_i (core0_if.wstrb),
        .instr_1_i (core1_if.instr),
        .addr_1_i  (core1_if.addr),
        .wdata_1_i (core1_if.wdata),
        .wstrb_1_i (core1_if.wstrb),
        .match_o   (req_match)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait1_d     = wait1_q;
        mem_valid_d = mem_valid_q;
        req_d       = req_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        code_d      = code_q;
        do_cmp      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (both_valid) begin
                    do_cmp = 1'b1;
                end else if (v0 || v1) begin
                    state_d = StWait;
                    cnt_d   = '0;
                    wait1_d = v1;
                end
            end
            StWait: begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
                if (!waiter_valid) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                    code_d  = ErrProtocol;
                end else if (both_valid) begin
                    // Partner arriving on the timeout cycle still gets compared.
                    do_cmp = 1'b1;
                end else if (cnt_q == CntMax) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                    code_d  = ErrTimeout;
                end
            end
            StIssue: begin
                if (!both_valid) begin
                    state_d     = StErr;
                    mem_valid_d = 1'b0;
                    err_d       = 1'b1;
                    code_d      = ErrProtocol;
                end else if (mem_if.ready) begin
                    state_d     = StResp;
                    mem_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    rdata_d     = mem_if.rdata;
                end
            end
            StResp: begin
                // Cores still hold valid this cycle; it is the finished request.
                state_d = StIdle;
            end
            StErr: begin
                if (err_clr) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                    code_d  = ErrNone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_cmp) begin
            if (req_match) begin
                state_d     = StIssue;
                mem_valid_d = 1'b1;
                req_d       = {core0_if.instr, core0_if.addr, core0_if.wdata, core0_if.wstrb};
            end else begin
                state_d = StErr;
                err_d   = 1'b1;
                code_d  = ErrMismatch;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wait1_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            req_q       <= '0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            code_q      <= ErrNone;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait1_q     <= wait1_d;
            mem_valid_q <= mem_valid_d;
            req_q       <= req_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    assign mem_if.valid   = mem_valid_q;
    assign mem_if.instr   = req_q.instr;
    assign mem_if.addr    = req_q.addr;
    assign mem_if.wdata   = req_q.wdata;
    assign mem_if.wstrb   = req_q.wstrb;

    assign core0_if.ready = ready_q;
    assign core0_if.rdata = rdata_q;
    assign core1_if.ready = ready_q;
    assign core1_if.rdata = rdata_q;

    assign lockstep_err   = err_q;
    assign err_code       = code_q;

endmodule

// File: tb/tb_lockstep_mem_ctrl.sv
// Self-checking bench for lockstep_mem_ctrl. Inputs change and outputs are sampled
// on the falling clock edge; expectations come from a transaction-level model.
module tb_lockstep_mem_ctrl;

    localparam int unsigned SKEW = 6;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       err_clr = 1'b0;
    logic       lockstep_err;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;

    lockstep_mem_ctrl_if c0 ();
    lockstep_mem_ctrl_if c1 ();
    lockstep_mem_ctrl_if mem ();

    lockstep_mem_ctrl #(.SKEW_MAX(SKEW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .core0_if     (c0),
        .core1_if     (c1),
        .mem_if       (mem),
        .err_clr      (err_clr),
        .lockstep_err (lockstep_err),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit ref_match(input req_t a, input req_t b);
        if (a.addr !== b.addr || a.instr !== b.instr || a.wstrb !== b.wstrb) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (a.wstrb[i] && (a.wdata[8*i +: 8] !== b.wdata[8*i +: 8])) return 1'b0;
        return 1'b1;
    endfunction

    // The waiting core's counter runs 0..SKEW in WAIT; a partner seen while the
    // counter reads SKEW is still accepted, so skews up to SKEW+1 are tolerated.
    function automatic logic [1:0] ref_code(input req_t a, input req_t b, input int skew);
        if (skew > int'(SKEW) + 1) return 2'b10;
        if (!ref_match(a, b)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.instr = 1'($urandom);
        r.addr  = {16'h0, 16'($urandom)} & 32'hFFFF_FFFC;
        r.wdata = $urandom;
        r.wstrb = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic set_core(input bit idx, input bit v, input req_t r);
        if (!idx) begin
            c0.valid = v; c0.instr = r.instr; c0.addr = r.addr;
            c0.wdata = r.wdata; c0.wstrb = r.wstrb;
        end else begin
            c1.valid = v; c1.instr = r.instr; c1.addr = r.addr;
            c1.wdata = r.wdata; c1.wstrb = r.wstrb;
        end
    endtask

    task automatic check_err_and_clear(input string name, input logic [1:0] code);
        req_t r;
        r = '{instr: 1'b0, addr: 32'h40, wdata: 32'h0, wstrb: 4'h0};
        set_core(0, 1'b1, r);
        set_core(1, 1'b1, r);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem.valid !== 1'b0 || c0.ready !== 1'b0 || c1.ready !== 1'b0 ||
                lockstep_err !== 1'b1 || err_code !== code) begin
                errors++;
                $display("FAIL %s_stall: valid=%b ready=%b%b err=%b code=%b, required 0 00 1 %b",
                         name, mem.valid, c0.ready, c1.ready, lockstep_err, err_code, code);
            end
        end
        set_core(0, 1'b0, r);
        set_core(1, 1'b0, r);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (lockstep_err !== 1'b0 || err_code !== 2'b00) begin
            errors++;
            $display("FAIL %s_clear: err=%b code=%b, required 0 00", name, lockstep_err, err_code);
        end
    endtask

    // One lockstep transaction: leader raises valid at t=0, follower at t=skew,
    // responder answers rdelay cycles after mem_valid first appears.
    task automatic run_txn(input string name, input req_t r0, input req_t r1, input int skew,
                           input bit lead1, input int rdelay, input logic [31:0] rd);
        logic [1:0]  exp_code;
        logic [1:0]  got_code;
        int          issue_t, ready_t, err_t, xfers, vcnt;
        bit          prev_valid, done, rdy0, rdy1;
        logic [31:0] rdat0, rdat1;
        req_t        rl, rf, seen;
        exp_code = ref_code(r0, r1, skew);
        issue_t = -1; ready_t = -1; err_t = -1; xfers = 0; vcnt = 0;
        prev_valid = 1'b0; done = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
        rdat0 = '0; rdat1 = '0; got_code = 2'b00;
        rl = lead1 ? r1 : r0;
        rf = lead1 ? r0 : r1;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (mem.ready && prev_valid) xfers++;
            prev_valid = mem.valid;
            if (mem.valid) begin
                vcnt++;
                if (issue_t < 0) begin
                    issue_t = t;
                    seen = {mem.instr, mem.addr, mem.wdata, mem.wstrb};
                    checks++;
                    if (seen !== r0) begin
                        errors++;
                        $display("FAIL %s_fields: got %h, required %h", name, seen, r0);
                    end
                end
            end
            if (c0.ready || c1.ready) begin
                ready_t = t; done = 1'b1;
                rdy0 = c0.ready; rdy1 = c1.ready; rdat0 = c0.rdata; rdat1 = c1.rdata;
            end
            if (lockstep_err) begin
                err_t = t; got_code = err_code; done = 1'b1;
            end
            mem.ready = 1'b0;
            mem.rdata = $urandom;
            if (done) begin
                set_core(0, 1'b0, r0);
                set_core(1, 1'b0, r1);
            end else begin
                set_core(lead1, 1'b1, rl);
                set_core(!lead1, (t >= skew), rf);
                if (mem.valid && vcnt == rdelay + 1) begin
                    mem.ready = 1'b1;
                    mem.rdata = rd;
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_budget: no ready or error within 60 cycles, required one", name);
            set_core(0, 1'b0, r0);
            set_core(1, 1'b0, r1);
        end else if (exp_code == 2'b00) begin
            if (ready_t != skew + 2 + rdelay || issue_t != skew + 1) begin
                errors++;
                $display("FAIL %s_latency: issue=%0d ready=%0d, required %0d %0d",
                         name, issue_t, ready_t, skew + 1, skew + 2 + rdelay);
            end
            checks++;
            if (rdy0 !== 1'b1 || rdy1 !== 1'b1 || rdat0 !== rd || rdat1 !== rd || err_t != -1) begin
                errors++;
                $display("FAIL %s_resp: ready=%b%b rdata=%h/%h err_t=%0d, required 11 %h -1",
                         name, rdy0, rdy1, rdat0, rdat1, err_t, rd);
            end
            checks++;
            if (xfers != 1) begin
                errors++;
                $display("FAIL %s_xfers: got %0d, required 1", name, xfers);
            end
            @(negedge clk);
            checks++;
            if (c0.ready !== 1'b0 || c1.ready !== 1'b0 || mem.valid !== 1'b0 ||
                c0.rdata !== rd || c1.rdata !== rd) begin
                errors++;
                $display("FAIL %s_after: ready=%b%b valid=%b rdata=%h, required 00 0 %h",
                         name, c0.ready, c1.ready, mem.valid, c0.rdata, rd);
            end
        end else begin
            if (got_code !== exp_code ||
                err_t != ((exp_code == 2'b10) ? int'(SKEW) + 2 : skew + 1)) begin
                errors++;
                $display("FAIL %s_err: code=%b at %0d, required %b at %0d", name, got_code, err_t,
                         exp_code, (exp_code == 2'b10) ? int'(SKEW) + 2 : skew + 1);
            end
            checks++;
            if (issue_t != -1 || ready_t != -1) begin
                errors++;
                $display("FAIL %s_noissue: issue=%0d ready=%0d, required -1 -1",
                         name, issue_t, ready_t);
            end
            check_err_and_clear(name, exp_code);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem.valid !== 1'b0 || c0.ready !== 1'b0 || c1.ready !== 1'b0 || c0.rdata !== '0 ||
            mem.addr !== '0 || lockstep_err !== 1'b0 || err_code !== 2'b00) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b%b rdata=%h addr=%h err=%b code=%b, required 0",
                     mem.valid, c0.ready, c1.ready, c0.rdata, mem.addr, lockstep_err, err_code);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        req_t a, b;
        a = '{instr: 1'b0, addr: 32'h100, wdata: 32'h1111_1111, wstrb: 4'h0};
        b = '{instr: 1'b0, addr: 32'h100, wdata: 32'h2222_2222, wstrb: 4'h0};
        run_txn("read", a, b, 0, 1'b0, 0, 32'hDEAD_BEEF);
    endtask

    task automatic test_skew_write();
        req_t a;
        a = '{instr: 1'b0, addr: 32'h200, wdata: 32'h1234_5678, wstrb: 4'b0011};
        run_txn("skew_write", a, a, 5, 1'b0, 1, 32'h0BAD_F00D);
        run_txn("skew_edge", a, a, int'(SKEW) + 1, 1'b1, 0, 32'hCAFE_0001);
    endtask

    task automatic test_masked_write();
        req_t a, b;
        a = '{instr: 1'b0, addr: 32'h300, wdata: 32'h1234_5678, wstrb: 4'b0011};
        b = a;
        b.wdata = 32'h9934_5678;
        run_txn("mask_byte3", a, b, 0, 1'b0, 0, 32'h5555_AAAA);
        b = a;
        b.wdata = 32'h1234_5600;
        run_txn("mask_byte0", a, b, 2, 1'b1, 0, 32'h0);
    endtask

    task automatic test_timeout();
        req_t a;
        a = '{instr: 1'b1, addr: 32'h80, wdata: 32'h0, wstrb: 4'h0};
        run_txn("timeout", a, a, int'(SKEW) + 2, 1'b1, 0, 32'h0);
    endtask

    task automatic test_mismatch_addr();
        req_t a, b;
        a = '{instr: 1'b0, addr: 32'h100, wdata: 32'h0, wstrb: 4'h0};
        b = a;
        b.addr = 32'h104;
        run_txn("addr_mismatch", a, b, 0, 1'b0, 0, 32'h0);
    endtask

    task automatic test_protocol();
        req_t a;
        bit   seen;
        a = '{instr: 1'b0, addr: 32'h500, wdata: 32'hA5A5_A5A5, wstrb: 4'hF};
        // Waiting core withdraws before its partner arrives.
        set_core(0, 1'b1, a);
        repeat (2) @(negedge clk);
        set_core(0, 1'b0, a);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (lockstep_err !== 1'b1 || err_code !== 2'b11) begin
            errors++;
            $display("FAIL proto_wait: err=%b code=%b, required 1 11", lockstep_err, err_code);
        end
        check_err_and_clear("proto_wait", 2'b11);
        // A core withdraws while the downstream transfer is outstanding.
        set_core(0, 1'b1, a);
        set_core(1, 1'b1, a);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mem.valid;
        end
        set_core(1, 1'b0, a);
        @(negedge clk);
        checks++;
        if (!seen || mem.valid !== 1'b0 || lockstep_err !== 1'b1 || err_code !== 2'b11) begin
            errors++;
            $display("FAIL proto_issue: issued=%b valid=%b err=%b code=%b, required 1 0 1 11",
                     seen, mem.valid, lockstep_err, err_code);
        end
        set_core(0, 1'b0, a);
        check_err_and_clear("proto_issue", 2'b11);
    endtask

    task automatic test_reset_mid();
        req_t a;
        bit   seen;
        a = '{instr: 1'b1, addr: 32'h600, wdata: 32'h0, wstrb: 4'h0};
        set_core(0, 1'b1, a);
        set_core(1, 1'b1, a);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mem.valid;
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (!seen || mem.valid !== 1'b0 || mem.addr !== '0 || c0.ready !== 1'b0 ||
            c1.ready !== 1'b0 || lockstep_err !== 1'b0 || err_code !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid: issued=%b valid=%b addr=%h ready=%b%b err=%b, required 1 0 0",
                     seen, mem.valid, mem.addr, c0.ready, c1.ready, lockstep_err);
        end
        set_core(0, 1'b0, a);
        set_core(1, 1'b0, a);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_txn("after_reset", a, a, 1, 1'b0, 2, 32'h7777_1234);
    endtask

    task automatic test_random();
        req_t a, b;
        int   skew, kind;
        for (int n = 0; n < 40; n++) begin
            a = rand_req();
            b = a;
            kind = $urandom_range(0, 5);
            case (kind)
                1: b.wdata = a.wdata ^ ($urandom & ~{{8{a.wstrb[3]}}, {8{a.wstrb[2]}},
                                                    {8{a.wstrb[1]}}, {8{a.wstrb[0]}}});
                2: b.addr = a.addr ^ 32'h4;
                3: b.wstrb = a.wstrb ^ (4'h1 << $urandom_range(0, 3));
                4: b.instr = ~a.instr;
                5: b.wdata = a.wdata ^ (32'h1 << $urandom_range(0, 31));
                default: b = a;
            endcase
            skew = ($urandom_range(0, 3) == 0) ? $urandom_range(SKEW, SKEW + 3)
                                               : $urandom_range(0, 3);
            run_txn("random", a, b, skew, 1'($urandom), $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin
        c0.valid = 1'b0; c0.instr = 1'b0; c0.addr = '0; c0.wdata = '0; c0.wstrb = '0;
        c1.valid = 1'b0; c1.instr = 1'b0; c1.addr = '0; c1.wdata = '0; c1.wstrb = '0;
        mem.ready = 1'b0;
        mem.rdata = '0;
        test_reset();
        test_read();
        test_skew_write();
        test_masked_write();
        test_timeout();
        test_mismatch_addr();
        test_protocol();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
